cnn_ifmap_loader: RTL and testbench

- Front-end stage directly upstream of cnn_accelerator.
- Accepts a serial valid/ready byte stream and assembles the kernel weight array and the full ifmap array in row-major order.
- Clears the accelerator, holds its enable high until it reports done, then signals frame completion.
- Replaces the file-driven loading used in simulation with a synthesizable ingest path.

---
 rtl/cnn_ifmap_loader_pkg.sv | 25 ++
 rtl/cnn_ifmap_loader_if.sv | 14 +
 rtl/cnn_ifmap_loader_rc_counter.sv | 37 +++
 rtl/cnn_ifmap_loader.sv | 153 +++++++++++++++
 tb/tb_cnn_ifmap_loader.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_ifmap_loader_pkg.sv
// Shared definitions for the CNN ifmap loader: array geometry, derived counts,
// loader state encoding and an index-width helper.
package cnn_defs;

  localparam int DATA_WIDTH   = 8;
  localparam int IFMAP_SIZE   = 28;
  localparam int KERNEL_SIZE  = 3;
  localparam int IFMAP_PIXELS = IFMAP_SIZE * IFMAP_SIZE;
  localparam int KERNEL_TAPS  = KERNEL_SIZE * KERNEL_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_WT = 3'd1,
    ST_LOAD_IF = 3'd2,
    ST_ARM     = 3'd3,
    ST_RUN     = 3'd4,
    ST_FIN     = 3'd5
  } loader_state_t;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_ifmap_loader_if.sv
// Valid/ready byte stream feeding the loader; master is the source, slave the loader.
interface cnn_ifmap_loader_if #(
  parameter int DATA_WIDTH = cnn_defs::DATA_WIDTH
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/cnn_ifmap_loader_rc_counter.sv
// Row/column index counter for a SIZE x SIZE array walked in row-major order;
// term flags the last element so the caller can detect the final beat.
module cnn_rc_counter
  import cnn_defs::*;
#(
  parameter int SIZE = 3,
  parameter int W    = idx_width(SIZE)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         term
);

  localparam logic [W-1:0] MAX_IDX = W'(SIZE - 1);

  assign term = (row == MAX_IDX) && (col == MAX_IDX);

  // Column advances per enable; wrapping it carries into the row.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == MAX_IDX) begin
        col <= '0;
        row <= (row == MAX_IDX) ? '0 : row + W'(1);
      end else begin
        col <= col + W'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_ifmap_loader.sv
// Stream ingest front-end for cnn_accelerator: fills the kernel and ifmap arrays
// from a byte stream, then clears and runs the accelerator for one frame.
module cnn_ifmap_loader
  import cnn_defs::*;
#(
  parameter int DATA_WIDTH  = cnn_defs::DATA_WIDTH,
  parameter int IFMAP_SIZE  = cnn_defs::IFMAP_SIZE,
  parameter int KERNEL_SIZE = cnn_defs::KERNEL_SIZE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         load_wt,
  cnn_ifmap_loader_if.slave            s,
  output logic        [DATA_WIDTH-1:0] cnn_ifmap [IFMAP_SIZE][IFMAP_SIZE],
  output logic signed [DATA_WIDTH-1:0] weights   [KERNEL_SIZE][KERNEL_SIZE],
  output logic                         acc_clr,
  output logic                         acc_en,
  input  logic                         acc_done,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err_len
);

  localparam int IW = idx_width(IFMAP_SIZE);
  localparam int KW = idx_width(KERNEL_SIZE);

  loader_state_t state;
  logic          rdy;
  logic [KW-1:0] wt_row, wt_col;
  logic [IW-1:0] px_row, px_col;
  logic          wt_term, px_term;
  logic          frame_start, wt_beat, px_beat;

  assign s.s_ready   = rdy;
  assign frame_start = (state == ST_IDLE) && start;
  assign wt_beat     = (state == ST_LOAD_WT) && s.s_valid && rdy;
  assign px_beat     = (state == ST_LOAD_IF) && s.s_valid && rdy;

  cnn_rc_counter #(.SIZE(KERNEL_SIZE), .W(KW)) u_wt_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (frame_start),
    .en    (wt_beat),
    .row   (wt_row),
    .col   (wt_col),
    .term  (wt_term)
  );

  cnn_rc_counter #(.SIZE(IFMAP_SIZE), .W(IW)) u_px_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (frame_start),
    .en    (px_beat),
    .row   (px_row),
    .col   (px_col),
    .term  (px_term)
  );

  // Frame sequencer; every output is set on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rdy        <= 1'b0;
      acc_clr    <= 1'b0;
      acc_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      acc_clr    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_len <= 1'b0;
            busy    <= 1'b1;
            rdy     <= 1'b1;
            state   <= load_wt ? ST_LOAD_WT : ST_LOAD_IF;
          end
        end
        ST_LOAD_WT: begin
          if (wt_beat && wt_term) begin
            state <= ST_LOAD_IF;
          end
        end
        ST_LOAD_IF: begin
          if (px_beat) begin
            if (px_term) begin
              if (!s.s_last) begin
                err_len <= 1'b1;
              end
              rdy     <= 1'b0;
              acc_clr <= 1'b1;
              state   <= ST_ARM;
            end else if (s.s_last) begin
              // Short frame: drop it without running the accelerator.
              err_len <= 1'b1;
              rdy     <= 1'b0;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end
          end
        end
        ST_ARM: begin
          acc_en <= 1'b1;
          state  <= ST_RUN;
        end
        ST_RUN: begin
          if (acc_done) begin
            acc_en     <= 1'b0;
            frame_done <= 1'b1;
            state      <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          rdy    <= 1'b0;
          acc_en <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Array writes happen only on accepted beats, so contents hold through ARM/RUN/FIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          weights[r][c] <= '0;
        end
      end
      for (int r = 0; r < IFMAP_SIZE; r++) begin
        for (int c = 0; c < IFMAP_SIZE; c++) begin
          cnn_ifmap[r][c] <= '0;
        end
      end
    end else begin
      if (wt_beat) begin
        weights[wt_row][wt_col] <= $signed(s.s_data);
      end
      if (px_beat) begin
        cnn_ifmap[px_row][px_col] <= s.s_data;
      end
    end
  end

endmodule

// File: tb/tb_cnn_ifmap_loader.sv
// Directed self-checking bench for cnn_ifmap_loader with a 4x4 ifmap and 3x3 kernel.
module tb_cnn_ifmap_loader;

  localparam int DW = 8;
  localparam int IS = 4;
  localparam int KS = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic load_wt = 1'b0;
  logic acc_done = 1'b0;
  logic acc_clr, acc_en, busy, frame_done, err_len;
  logic        [DW-1:0] cnn_ifmap [IS][IS];
  logic signed [DW-1:0] weights   [KS][KS];

  cnn_ifmap_loader_if #(.DATA_WIDTH(DW)) bus ();

  cnn_ifmap_loader #(.DATA_WIDTH(DW), .IFMAP_SIZE(IS), .KERNEL_SIZE(KS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_wt    (load_wt),
    .s          (bus),
    .cnn_ifmap  (cnn_ifmap),
    .weights    (weights),
    .acc_clr    (acc_clr),
    .acc_en     (acc_en),
    .acc_done   (acc_done),
    .busy       (busy),
    .frame_done (frame_done),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tmo = 0;
  int clr_cnt = 0;
  int en_cnt = 0;
  int fd_cnt = 0;
  logic [7:0] wt_vec [9];
  logic [7:0] px_vec [16];
  int last_at;

  // Pulse/level counters for the accelerator handshake outputs.
  always @(negedge clk) begin
    clr_cnt += int'(acc_clr);
    en_cnt  += int'(acc_en);
    fd_cnt  += int'(frame_done);
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    @(posedge clk);
    #1;
    clr_cnt = 0;
    en_cnt = 0;
    fd_cnt = 0;
    tmo = 0;
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input bit gaps);
    int n;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      bus.s_valid = 1'b0;
      @(negedge clk);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) tmo++;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input bit lw, input bit gaps);
    start = 1'b1;
    load_wt = lw;
    @(negedge clk);
    start = 1'b0;
    load_wt = 1'b0;
    if (lw) begin
      for (int i = 0; i < 9; i++) send_beat(wt_vec[i], 1'b0, gaps);
    end
    for (int i = 0; i < 16; i++) begin
      send_beat(px_vec[i], (i == last_at), gaps);
      if (i == last_at) break;
    end
  endtask

  task automatic run_accel();
    int n;
    n = 0;
    while (acc_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) tmo++;
    repeat (5) @(negedge clk);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    @(negedge clk);
    check("timeouts", tmo, 0);
  endtask

  task automatic nominal_vectors();
    for (int i = 0; i < 9; i++) wt_vec[i] = 8'(i + 1);
    for (int i = 0; i < 16; i++) px_vec[i] = 8'(i + 10);
    last_at = 15;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.s_ready, 0);
    check("rst_en", acc_en, 0);
    check("rst_clr", acc_clr, 0);
    check("rst_fd", frame_done, 0);
    check("rst_err", err_len, 0);
    check("rst_w00", weights[0][0], 0);
    check("rst_if33", cnn_ifmap[3][3], 0);
    reset = 1'b0;
    @(negedge clk);

    // Nominal load
    nominal_vectors();
    clear_counts();
    start = 1'b1;
    load_wt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_wt = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", bus.s_ready, 1);
    for (int i = 0; i < 9; i++) send_beat(wt_vec[i], 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) send_beat(px_vec[i], (i == 15), 1'b0);
    check("arm_clr", acc_clr, 1);
    check("arm_ready", bus.s_ready, 0);
    run_accel();
    check("nom_w22", weights[2][2], 9);
    check("nom_w00", weights[0][0], 1);
    check("nom_w12", weights[1][2], 6);
    check("nom_if00", cnn_ifmap[0][0], 10);
    check("nom_if12", cnn_ifmap[1][2], 16);
    check("nom_if33", cnn_ifmap[3][3], 25);
    check("nom_clr_cnt", clr_cnt, 1);
    check("nom_en_cnt", en_cnt, 6);
    check("nom_fd_cnt", fd_cnt, 1);
    check("nom_err", err_len, 0);
    check("nom_busy", busy, 0);

    // Back-pressure and gaps, starting from cleared arrays
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("clr_if33", cnn_ifmap[3][3], 0);
    clear_counts();
    send_frame(1'b1, 1'b1);
    run_accel();
    for (int r = 0; r < KS; r++)
      for (int c = 0; c < KS; c++) check("gap_w", weights[r][c], r * 3 + c + 1);
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++) check("gap_if", cnn_ifmap[r][c], r * 4 + c + 10);
    check("gap_fd_cnt", fd_cnt, 1);

    // Weight reuse
    for (int i = 0; i < 16; i++) px_vec[i] = 8'h80;
    clear_counts();
    send_frame(1'b0, 1'b0);
    run_accel();
    for (int r = 0; r < KS; r++)
      for (int c = 0; c < KS; c++) check("reuse_w", weights[r][c], r * 3 + c + 1);
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++) check("reuse_if", cnn_ifmap[r][c], 128);
    check("reuse_fd_cnt", fd_cnt, 1);

    // Signed weights
    wt_vec[0] = 8'hFF;
    wt_vec[1] = 8'h80;
    wt_vec[2] = 8'h7F;
    for (int i = 0; i < 16; i++) px_vec[i] = 8'(i);
    clear_counts();
    send_frame(1'b1, 1'b0);
    run_accel();
    check("sgn_w00", weights[0][0], -1);
    check("sgn_w01", weights[0][1], -128);
    check("sgn_w02", weights[0][2], 127);
    check("sgn_w10", weights[1][0], 4);

    // acc_done outside RUN
    clear_counts();
    acc_done = 1'b1;
    repeat (3) @(negedge clk);
    acc_done = 1'b0;
    check("idle_done_busy", busy, 0);
    check("idle_done_fd", fd_cnt, 0);
    check("idle_done_en", en_cnt, 0);

    // Early s_last on pixel 7
    for (int i = 0; i < 16; i++) px_vec[i] = 8'(i + 30);
    last_at = 6;
    clear_counts();
    send_frame(1'b0, 1'b0);
    check("early_busy", busy, 0);
    check("early_err", err_len, 1);
    check("early_ready", bus.s_ready, 0);
    check("early_if12", cnn_ifmap[1][2], 36);
    repeat (10) @(negedge clk);
    check("early_clr_cnt", clr_cnt, 0);
    check("early_en_cnt", en_cnt, 0);
    check("early_fd_cnt", fd_cnt, 0);
    check("early_tmo", tmo, 0);

    // Missing s_last on pixel 16; start must clear err_len first
    last_at = -1;
    clear_counts();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_clr_err", err_len, 0);
    for (int i = 0; i < 16; i++) send_beat(px_vec[i], 1'b0, 1'b0);
    run_accel();
    check("nolast_err", err_len, 1);
    check("nolast_fd_cnt", fd_cnt, 1);
    check("nolast_en_cnt", en_cnt, 6);
    check("nolast_if33", cnn_ifmap[3][3], 45);

    // Reset mid-RUN
    nominal_vectors();
    clear_counts();
    send_frame(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_en", acc_en, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_en_off", acc_en, 0);
    check("mid_busy", busy, 0);
    check("mid_ready", bus.s_ready, 0);
    check("mid_w22", weights[2][2], 0);
    check("mid_if33", cnn_ifmap[3][3], 0);
    clear_counts();
    send_frame(1'b1, 1'b0);
    run_accel();
    check("post_w22", weights[2][2], 9);
    check("post_if33", cnn_ifmap[3][3], 25);
    check("post_clr_cnt", clr_cnt, 1);
    check("post_en_cnt", en_cnt, 6);
    check("post_fd_cnt", fd_cnt, 1);
    check("post_err", err_len, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
